// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter
// and the unified RAM. slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_w_op;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_w_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  d_req, d_we, d_w_op, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_en, mem_we, mem_w_op, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output d_req, d_we, d_w_op, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_en, mem_we, mem_w_op, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch (I) and load/store (D).
// Define ARB_RR_EN for round-robin arbitration; default is D-over-I priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] W_W    = 2'b10;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_q;
  logic              we_q;
  logic [1:0]        wop_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic grant;
  logic pick_d;
  logic last_beat;

  assign grant = (state_q == IDLE) &&
                 (bus.if_req || bus.d_req);

  // gnt_q doubles as last_gnt: 1 = D side won most recently
  assign pick_d = bus.d_req &&
                  (!bus.if_req || !RR || !gnt_q);

  assign last_beat = (state_q == BUSY) &&
                     (cnt_q == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en = 1'b0;
    bus.mem_we = 1'b0;
    bus.if_ack = 1'b0;
    bus.d_ack  = 1'b0;
    unique case (state_q)
      BUSY: begin
        bus.mem_en = 1'b1;
        bus.mem_we = we_q && (cnt_q == LAT_M1);
      end
      RESP: begin
        bus.if_ack = !gnt_q;
        bus.d_ack  = gnt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      wop_q      <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant) begin
        gnt_q   <= pick_d;
        we_q    <= pick_d && bus.d_we;
        wop_q   <= pick_d ? bus.d_w_op : W_W;
        addr_q  <= pick_d ? bus.d_addr : bus.if_addr;
        wdata_q <= pick_d ? bus.d_wdata : '0;
      end
      if (last_beat) begin
        if (gnt_q)
          d_rdata_q <= we_q ? '0 : bus.mem_rdata;
        else
          if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_w_op  = wop_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
